rom_arbiter: RTL

- Shares one single-port synchronous-read ROM between NUM_REQ requesters.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin; sustained throughput is one read per cycle.
- Sits between client blocks and the ROM. The ROM registers its address on clk and drives data combinationally from that register, so data arrives one cycle after the address.

---
 rtl/rom_arbiter_pkg.sv | 17 +
 rtl/rom_arbiter_if.sv | 32 +++
 rtl/rom_arbiter_rr_arbiter.sv | 62 ++++++
 rtl/rom_arbiter.sv | 97 +++++++++
 4 files changed

// File: rtl/rom_arbiter_pkg.sv
// Shared constants for the ROM arbiter: default widths, requester limit and an
// index-width helper used by every file of this block.
// No logic; no latency or flow-control behaviour of its own.
package rom_arbiter_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int MIN_NUM_REQ    = 2;
  localparam int MAX_NUM_REQ    = 8;

  // Width of a binary requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Request/response bundle between the client blocks and the ROM arbiter.
// Purely wires: request is valid/ready per requester, response is one-hot valid
// with a shared data/address bus and per-requester ready.
interface rom_arbiter_if
  import rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ-1:0]            rsp_ready;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic [ADDR_WIDTH-1:0]         rsp_addr;

  // Client side.
  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_addr
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_addr
  );

endinterface

// File: rtl/rom_arbiter_rr_arbiter.sv
// Combinational one-hot arbiter: round-robin after 'last', or lowest index wins
// when ROM_ARB_FIXED_PRIO_EN is defined. Zero latency.
// Backpressure: 'en' low forces an all-zero grant.
module rr_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDXW    = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    last,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDXW-1:0]    grant_idx
);

  logic          found;
  logic [IDXW-1:0] sel;

`ifdef ROM_ARB_FIXED_PRIO_EN
  // The pointer has no meaning with fixed priority.
  logic unused_last;
  assign unused_last = ^last;

  // Lowest-index valid request wins; scan downward so the last hit is the lowest.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        sel   = IDXW'(i);
      end
    end
  end
`else
  // Scan starting one past the previous winner, wrapping modulo NUM_REQ.
  always_comb begin
    logic [IDXW-1:0] cand;
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDXW'((int'(last) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end
`endif

  // Expand the winner to one-hot, suppressed when issuing is not allowed.
  always_comb begin
    grant     = '0;
    grant_idx = sel;
    if (en && found) begin
      grant[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one synchronous-read ROM among NUM_REQ requesters; round-robin, or fixed
// priority with ROM_ARB_FIXED_PRIO_EN. Response one cycle after the request handshake.
// Backpressure: a held response freezes the stage, ROM address and all grants.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  rom_arbiter_if.slave          bus,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data
);

  localparam int IDXW = idx_w(NUM_REQ);

  logic                  pend_valid;
  logic [IDXW-1:0]       pend_id;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [IDXW-1:0]       last_grant;

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic                  can_issue;
  logic                  rsp_accept;
  logic                  issue;
  logic [NUM_REQ-1:0]    grant;
  logic [IDXW-1:0]       grant_idx;

  // Unpack the flat address bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // An accepted response frees the stage in the same cycle; nothing is
  // granted while reset is asserted.
  assign rsp_accept = pend_valid && bus.rsp_ready[pend_id];
  assign can_issue  = !rst && (!pend_valid || bus.rsp_ready[pend_id]);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_arb (
    .req       (bus.req_valid),
    .last      (last_grant),
    .en        (can_issue),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign issue         = |grant;
  assign bus.req_ready = grant;

  // On issue the ROM latches the new address; otherwise it re-latches the
  // pending one so the shared data bus stays stable through a hold.
  always_comb begin
    rom_addr = pend_addr;
    if (issue) begin
      rom_addr = addr_arr[grant_idx];
    end
  end

  // One-entry response stage and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_id    <= '0;
      pend_addr  <= '0;
      last_grant <= IDXW'(NUM_REQ - 1);
    end else if (issue) begin
      pend_valid <= 1'b1;
      pend_id    <= grant_idx;
      pend_addr  <= addr_arr[grant_idx];
      last_grant <= grant_idx;
    end else if (rsp_accept) begin
      pend_valid <= 1'b0;
    end
  end

  // One-hot response ownership; data and address are shared by all requesters.
  always_comb begin
    bus.rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pend_valid && pend_id == IDXW'(i)) begin
        bus.rsp_valid[i] = 1'b1;
      end
    end
  end

  assign bus.rsp_data = rom_data;
  assign bus.rsp_addr = pend_addr;

endmodule
